// File: rtl/melody_sequencer_if.sv
// Bundles the host configuration port and the lookup/tone-generator datapath
// of the melody sequencer; the host side drives master, the sequencer is slave.
interface melody_sequencer_if;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic [3:0]  last_step;
  logic        loop;
  logic        start;
  logic        stop;
  logic [15:0] lut_div;
  logic [3:0]  lut_note;
  logic [3:0]  lut_octave;
  logic [15:0] tone_div;
  logic        tone_en;
  logic        busy;
  logic [3:0]  step;
  logic        done;

  modport master (
    output wr_en, wr_addr, wr_data, last_step, loop, start, stop, lut_div,
    input  lut_note, lut_octave, tone_div, tone_en, busy, step, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, last_step, loop, start, stop, lut_div,
    output lut_note, lut_octave, tone_div, tone_en, busy, step, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Steps through a small pattern RAM, feeds each note to the divider lookup and
// plays the returned divider on the tone generator for a tempo-scaled time.
module melody_sequencer #(
  parameter int DEPTH       = 16,
  parameter int TICK_CYCLES = 12000,
  parameter int LUT_LATENCY = 1
) (
  input logic               clk,
  input logic               rstn,
  melody_sequencer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int WW = $clog2(LUT_LATENCY + 2);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} state_t;

  state_t        state;
  state_t        next_state;
  logic [11:0]   mem [DEPTH];
  logic [11:0]   entry;
  logic [3:0]    step_q;
  logic [3:0]    last_q;
  logic [3:0]    last_clamped;
  logic [3:0]    cur_len;
  logic [3:0]    dur_cnt;
  logic [3:0]    note_q;
  logic [3:0]    octave_q;
  logic [15:0]   tone_div_q;
  logic          tone_en_q;
  logic          done_q;
  logic [PW-1:0] presc;
  logic [WW-1:0] wait_cnt;
  logic          wait_done;
  logic          tick_wrap;
  logic          play_end;
  logic          at_last;
  logic          is_rest;
  logic          busy_c;

  assign entry        = mem[step_q[AW-1:0]];
  assign last_clamped = ({1'b0, bus.last_step} >= 5'(DEPTH)) ? 4'(DEPTH - 1) : bus.last_step;
  assign wait_done    = (wait_cnt == WW'(LUT_LATENCY));
  assign tick_wrap    = (presc == PW'(TICK_CYCLES - 1));
  assign play_end     = tick_wrap && (dur_cnt == cur_len);
  assign at_last      = (step_q == last_q);
  assign is_rest      = (note_q >= 4'd12) || (octave_q >= 4'd9);

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // stop overrides every other transition, including start and step end
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start) next_state = FETCH;
      FETCH:   next_state = WAIT;
      WAIT:    if (wait_done) next_state = PLAY;
      PLAY:    if (play_end) next_state = (!at_last || bus.loop) ? FETCH : IDLE;
      default: next_state = IDLE;
    endcase
    if (bus.stop) next_state = IDLE;
  end

  always_comb begin
    busy_c = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_q     <= '0;
      last_q     <= '0;
      cur_len    <= '0;
      dur_cnt    <= '0;
      note_q     <= '0;
      octave_q   <= '0;
      tone_div_q <= '0;
      tone_en_q  <= 1'b0;
      done_q     <= 1'b0;
      presc      <= '0;
      wait_cnt   <= '0;
    end else begin
      done_q    <= (state == PLAY) && (next_state == IDLE) && !bus.stop;
      tone_en_q <= (next_state == PLAY) && ((state == WAIT) ? !is_rest : tone_en_q);
      wait_cnt  <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == IDLE && next_state == FETCH) begin
        step_q <= '0;
        last_q <= last_clamped;
      end
      if (state == FETCH && next_state == WAIT) begin
        note_q   <= entry[3:0];
        octave_q <= entry[7:4];
        cur_len  <= entry[11:8];
      end
      // the divider is captured as the lookup output settles, once per step
      if (state == WAIT && next_state == PLAY) begin
        tone_div_q <= bus.lut_div;
        presc      <= '0;
        dur_cnt    <= '0;
      end else if (state == PLAY) begin
        presc <= tick_wrap ? '0 : presc + 1'b1;
        if (tick_wrap) dur_cnt <= dur_cnt + 1'b1;
      end
      if (state == PLAY && next_state == FETCH) begin
        step_q <= at_last ? 4'd0 : step_q + 4'd1;
      end
    end
  end

  assign bus.lut_note   = note_q;
  assign bus.lut_octave = octave_q;
  assign bus.tone_div   = tone_div_q;
  assign bus.tone_en    = tone_en_q;
  assign bus.busy       = busy_c;
  assign bus.step       = step_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed scenarios plus random
// traffic, compared every cycle against a step/offset timeline model.
module tb_melody_sequencer;
  localparam int TICK  = 4;
  localparam int LAT   = 1;
  localparam int DEPTH = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  melody_sequencer_if sif ();

  melody_sequencer #(
    .DEPTH(DEPTH),
    .TICK_CYCLES(TICK),
    .LUT_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(sif)
  );

  // divider lookup stand-in: one cycle of latency
  always @(posedge clk or negedge rstn) begin
    if (!rstn) sif.lut_div <= '0;
    else       sif.lut_div <= {sif.lut_octave, sif.lut_note, 8'hA5};
  end

  int errors = 0;
  int checks = 0;
  int cnt_busy, cnt_en, cnt_done;

  logic [11:0] ram [DEPTH];
  bit          m_busy, m_en, m_done;
  logic [3:0]  m_step, m_last, m_note, m_oct, m_len;
  logic [15:0] m_div;
  int          m_t;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_en = 0; m_done = 0;
    m_step = 0; m_last = 0; m_note = 0; m_oct = 0; m_len = 0;
    m_div = 0; m_t = 0;
  endtask

  // m_t is the cycle offset since this step's fetch cycle; the step period is
  // 2 + LAT + (len+1)*TICK, with the tone starting at offset LAT+2
  task automatic model_edge();
    int period;
    if (!rstn) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (sif.stop) begin
      m_busy = 0;
      m_en   = 0;
    end else if (!m_busy) begin
      if (sif.start) begin
        m_busy = 1;
        m_step = 0;
        m_last = (int'(sif.last_step) >= DEPTH) ? 4'(DEPTH - 1) : sif.last_step;
        m_t    = 0;
      end
    end else if (m_t == 0) begin
      m_note = ram[m_step][3:0];
      m_oct  = ram[m_step][7:4];
      m_len  = ram[m_step][11:8];
      m_en   = 0;
      m_t    = 1;
    end else begin
      period = 2 + LAT + (int'(m_len) + 1) * TICK;
      if (m_t == LAT + 1) begin
        m_div = {m_oct, m_note, 8'hA5};
        m_en  = !(m_note >= 12 || m_oct >= 9);
      end
      if (m_t == period - 1) begin
        m_en = 0;
        m_t  = 0;
        if (m_step != m_last) m_step = m_step + 4'd1;
        else if (sif.loop)    m_step = 0;
        else begin
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        m_t++;
      end
    end
    if (sif.wr_en) ram[sif.wr_addr] = sif.wr_data;
  endtask

  task automatic compare_all();
    checkOutput("busy",       16'(sif.busy),       16'(m_busy));
    checkOutput("tone_en",    16'(sif.tone_en),    16'(m_en));
    checkOutput("done",       16'(sif.done),       16'(m_done));
    checkOutput("step",       16'(sif.step),       16'(m_step));
    checkOutput("tone_div",   sif.tone_div,        m_div);
    checkOutput("lut_note",   16'(sif.lut_note),   16'(m_note));
    checkOutput("lut_octave", 16'(sif.lut_octave), 16'(m_oct));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (sif.busy)    cnt_busy++;
    if (sif.tone_en) cnt_en++;
    if (sif.done)    cnt_done++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic applyStimulus(input bit st, input bit sp);
    sif.start = st;
    sif.stop  = sp;
    cycle();
    sif.start = 1'b0;
    sif.stop  = 1'b0;
  endtask

  task automatic write_ram(input logic [3:0] addr, input logic [11:0] data);
    sif.wr_en   = 1'b1;
    sif.wr_addr = addr;
    sif.wr_data = data;
    cycle();
    sif.wr_en   = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_busy = 0; cnt_en = 0; cnt_done = 0;
  endtask

  initial begin
    int guard;
    sif.wr_en = 0; sif.wr_addr = 0; sif.wr_data = 0;
    sif.last_step = 0; sif.loop = 0; sif.start = 0; sif.stop = 0;
    model_reset();
    clear_counts();

    run(3);
    #2 rstn = 1'b1;
    run(2);

    $display("[TB] single note");
    write_ram(4'd0, 12'h049);
    sif.last_step = 4'd0;
    sif.loop = 1'b0;
    clear_counts();
    applyStimulus(1'b1, 1'b0);
    run(12);
    checkOutput("single_busy_cycles", 16'(cnt_busy), 16'd7);
    checkOutput("single_tone_cycles", 16'(cnt_en),   16'd4);
    checkOutput("single_done_pulses", 16'(cnt_done), 16'd1);

    $display("[TB] three steps with rest");
    write_ram(4'd1, 12'h13C);
    write_ram(4'd2, 12'h257);
    sif.last_step = 4'd2;
    clear_counts();
    applyStimulus(1'b1, 1'b0);
    run(40);
    checkOutput("three_busy_cycles", 16'(cnt_busy), 16'd33);
    checkOutput("three_tone_cycles", 16'(cnt_en),   16'd16);
    checkOutput("three_done_pulses", 16'(cnt_done), 16'd1);

    $display("[TB] loop");
    sif.last_step = 4'd1;
    sif.loop = 1'b1;
    clear_counts();
    applyStimulus(1'b1, 1'b0);
    run(20);
    checkOutput("loop_no_done", 16'(cnt_done), 16'd0);
    sif.loop = 1'b0;
    run(30);
    checkOutput("loop_end_done", 16'(cnt_done), 16'd1);

    $display("[TB] stop and restart");
    sif.last_step = 4'd2;
    sif.loop = 1'b1;
    clear_counts();
    applyStimulus(1'b1, 1'b0);
    run(5);
    applyStimulus(1'b1, 1'b0);
    run(18);
    applyStimulus(1'b0, 1'b1);
    checkOutput("stop_busy",    16'(sif.busy),    16'd0);
    checkOutput("stop_tone_en", 16'(sif.tone_en), 16'd0);
    run(3);
    checkOutput("stop_no_done", 16'(cnt_done), 16'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("start_stop_idle", 16'(sif.busy), 16'd0);
    applyStimulus(1'b1, 1'b0);
    run(10);
    applyStimulus(1'b0, 1'b1);
    run(2);

    $display("[TB] write while playing and async reset");
    sif.last_step = 4'd1;
    applyStimulus(1'b1, 1'b0);
    run(12);
    write_ram(4'd1, 12'h052);
    run(30);
    guard = 0;
    while (!(m_busy && m_t == 1) && guard < 100) begin
      cycle();
      guard++;
    end
    checkOutput("reach_wait", 16'(guard < 100), 16'd1);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    compare_all();
    run(2);
    #3 rstn = 1'b1;
    run(2);

    $display("[TB] random traffic");
    for (int i = 0; i < DEPTH; i++) write_ram(4'(i), 12'($urandom));
    for (int i = 0; i < 4000; i++) begin
      sif.start     = ($urandom_range(3) == 0);
      sif.stop      = ($urandom_range(127) == 0);
      sif.wr_en     = ($urandom_range(15) == 0);
      sif.wr_addr   = 4'($urandom);
      sif.wr_data   = 12'($urandom);
      sif.last_step = 4'($urandom);
      if ($urandom_range(63) == 0) sif.loop = ~sif.loop;
      cycle();
    end
    sif.wr_en = 1'b0;
    applyStimulus(1'b0, 1'b1);
    run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a stored melody through the note-to-divider lookup. Holds a small pattern RAM of note/octave/length steps and sequences the lookup's note and octave inputs. It waits out the lookup latency, then hands the resulting 16-bit divider to the square-wave tone generator for a tempo-scaled duration. It sits between the host configuration port and the lookup/tone-generator datapath.

## Interface
- DEPTH, 16: pattern steps (power of two, ≤16)
- TICK_CYCLES, 12000: clk cycles per duration tick (tempo prescaler)
- LUT_LATENCY, 1: clk cycles from note/octave input to valid divider output of the lookup
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- wr_en  in  1  pattern RAM write strobe
- wr_addr  in  4  write address (upper bits ignored when DEPTH<16)
- wr_data  in  12  step entry {len[11:8], octave[7:4], note[3:0]}
- last_step  in  4  index of final step; sampled on start
- loop  in  1  1 = restart at step 0 after last_step; sampled every step end
- start  in  1  begin playback (ignored unless IDLE)
- stop  in  1  abort playback (any state)
- lut_div  in  16  divider returned by lookup
- lut_note  out  4  note index to lookup (registered)
- lut_octave  out  4  octave to lookup (registered)
- tone_div  out  16  divider to tone generator (registered)
- tone_en  out  1  tone generator enable
- busy  out  1  high in any state except IDLE
- step  out  4  current step index
- done  out  1  one-cycle pulse at non-looping sequence end

## Operation
- Reset: state IDLE; all outputs 0; prescaler, duration counter and latched last_step cleared. RAM contents undefined.
- RAM: synchronous write on wr_en in any state. A write to the playing step affects only its next fetch.
- IDLE: start=1 → step←0, last_step latched, → FETCH.
- FETCH (1 cycle): read RAM[step]. Register lut_note/lut_octave and len into cur_len. Set tone_en←0. → WAIT.
- WAIT (LUT_LATENCY+1 cycles): tone_en stays 0. On the exiting edge: tone_div←lut_div, prescaler and duration counter cleared, → PLAY.
- PLAY: tone_en=1 unless the entry is a rest.
  - Rest: note ≥12 or octave ≥9. tone_div is still loaded but tone_en stays 0.
  - Prescaler wraps every TICK_CYCLES cycles. The duration counter increments on each wrap.
  - PLAY ends after exactly (cur_len+1)×TICK_CYCLES cycles.
- Step end:
  - step≠last_step: step←step+1, → FETCH.
  - step=last_step and loop=1: step←0, → FETCH.
  - step=last_step and loop=0: → IDLE, tone_en←0, done=1 for one cycle, step holds last_step.
- last_step ≥ DEPTH: treated as DEPTH-1.
- stop=1 in any state → IDLE on the next edge. tone_en←0, no done pulse, tone_div and step hold. stop has priority over start and over step end.
- start while busy: ignored. start and stop in the same cycle in IDLE: stay IDLE.
- Async reset mid-playback: immediate return to reset values.

## Timing
- Edge E0 samples start → FETCH. E1 → WAIT, lut_note/lut_octave valid. E(LUT_LATENCY+2) → PLAY, tone_div/tone_en valid.
- Per-step period, FETCH entry to next FETCH entry: 2 + LUT_LATENCY + (len+1)×TICK_CYCLES cycles.
- Silent gap between consecutive notes: 2+LUT_LATENCY cycles.
- busy rises the cycle after start is sampled. busy falls in the same edge as the done pulse or stop.
- done asserted for exactly one cycle, coincident with entry into IDLE.

## Test plan
Bench parameters: TICK_CYCLES=4, LUT_LATENCY=1. Lookup model returns lut_div={octave,note,8'hA5} one cycle after its inputs change.
- Reset: hold rstn=0, then release → busy=0, tone_en=0, tone_div=0, step=0, done=0.
- Single note: RAM[0]=12'h0_4_9, last_step=0, loop=0, pulse start.
  - lut_note=9 / lut_octave=4 one edge after FETCH.
  - tone_div=16'h49A5 and tone_en=1 three edges after start is sampled, for 4 cycles.
  - done pulses once; total busy 7 cycles.
- Three steps with lens 0, 1, 2 and a rest at step 1 (note 12):
  - step sequence 0, 1, 2 with PLAY lengths 4, 8, 12 cycles.
  - tone_en stays 0 during step 1.
  - 3-cycle gaps between notes.
- Loop: last_step=1, loop=1 → step wraps 1→0 with no done. Then set loop=0 mid-step 0 → sequence ends after step 1 with one done pulse.
- Stop and restart: stop asserted mid-PLAY of step 2 → IDLE next edge, tone_en=0, no done. Start during busy earlier in the run is ignored. A new start replays from step 0.
- Write while playing, async reset: write RAM[1] while step 1 plays → new value heard on the next loop pass. Drive rstn low mid-WAIT → all outputs 0 immediately.
